// File: rtl/udp_tx_checksum_engine.sv
// udp_tx_checksum_engine: store-and-forward UDP/IPv4 transmitter with RFC 768 checksum insertion.
// Latency: L4 commit -> L3 start 2 cycles; L3 start -> first payload word 3 cycles.
// Backpressure: none toward L3; the application waits for busy=0 before the next start.
//
// Ports
//   clk        sole clock, posedge
//   rst        synchronous active-high reset
//   our_ip     local IPv4 address, sampled with tx_l4_bus start
//   tx_l4_bus  [118:0] {start, dst_ip[31:0], src_port[15:0], dst_port[15:0], payload_len[15:0],
//                       data[31:0], bytes_valid[2:0], data_valid, commit, drop}
//   tx_l3_bus  [94:0]  {start, dst_ip[31:0], protocol[7:0], payload_len[15:0],
//                       data[31:0], bytes_valid[2:0], data_valid, commit, drop}
//   busy       high from the cycle after an accepted start through the L3 commit cycle
//   tx_error   one-cycle pulse when a datagram is discarded (oversize, length mismatch, overflow)
//
// Build option: define UDP_TX_CHECKSUM_EN to compute the checksum; without it the
// checksum field is sent as 16'h0000 and the FOLD cycle is kept so timing is unchanged.
module udp_tx_checksum_engine #(
  parameter int MAX_PAYLOAD = 1472,
  parameter int DEPTH_WORDS = 512
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  our_ip,
  input  logic [118:0] tx_l4_bus,
  output logic [94:0]  tx_l3_bus,
  output logic         busy,
  output logic         tx_error
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int PW = $clog2(DEPTH_WORDS + 1);
  localparam logic [7:0]    IP_PROTO_UDP = 8'd17;
  localparam logic [15:0]   MAX_LEN      = 16'(MAX_PAYLOAD);
  localparam logic [PW-1:0] FULL_WORDS   = PW'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    IDLE, BUFFER, FOLD, L3_START, HDR0, HDR1, BODY, COMMIT
  } state_t;

  // Application bus fields
  logic        l4_start, l4_dvld, l4_commit, l4_drop;
  logic [31:0] l4_dst_ip, l4_data;
  logic [15:0] l4_src_port, l4_dst_port, l4_len;
  logic [2:0]  l4_bv;

  assign {l4_start, l4_dst_ip, l4_src_port, l4_dst_port, l4_len,
          l4_data, l4_bv, l4_dvld, l4_commit, l4_drop} = tx_l4_bus;

  // Datagram context and pointers
  state_t        state;
  logic [31:0]   dst_ip_q;
  logic [15:0]   src_port_q, dst_port_q, len_q;
  logic [15:0]   rx_bytes;
  logic [15:0]   out_cnt;
  logic [PW-1:0] wr_ptr, rd_ptr;

  // Registered L3 outputs
  logic        o_start, o_dvld, o_commit;
  logic [31:0] o_dst_ip, o_data;
  logic [7:0]  o_protocol;
  logic [15:0] o_len;
  logic [2:0]  o_bv;

  assign tx_l3_bus = {o_start, o_dst_ip, o_protocol, o_len, o_data, o_bv, o_dvld, o_commit, 1'b0};

  // Payload buffer: {bytes_valid, data} per word, one-cycle read latency
  logic [34:0] mem [DEPTH_WORDS];
  logic [34:0] rd_dat;
  logic        wr_en;

  // Byte masking: bytes beyond bytes_valid count as zero in both RAM and checksum
  logic [2:0]  bv_eff;
  logic [31:0] data_masked;
  logic [15:0] rx_total, len8, n_words;
  logic        buf_full;

  always_comb begin
    bv_eff = (l4_bv > 3'd4) ? 3'd4 : l4_bv;
    case (bv_eff)
      3'd0:    data_masked = 32'h0;
      3'd1:    data_masked = {l4_data[31:24], 24'h0};
      3'd2:    data_masked = {l4_data[31:16], 16'h0};
      3'd3:    data_masked = {l4_data[31:8], 8'h0};
      default: data_masked = l4_data;
    endcase
  end

  assign rx_total = rx_bytes + (l4_dvld ? {13'h0, bv_eff} : 16'h0);
  assign len8     = len_q + 16'd8;
  assign n_words  = (len_q + 16'd3) >> 2;
  assign buf_full = (wr_ptr == FULL_WORDS);
  assign wr_en    = (state == BUFFER) && l4_dvld && !buf_full && !l4_drop;

`ifdef UDP_TX_CHECKSUM_EN
  logic [31:0] acc, seed, acc_next;
  logic [32:0] acc_sum;
  logic [16:0] fold1;
  logic [15:0] fold2, csum_raw, csum_q, l4_len8;

  always_comb begin
    l4_len8 = l4_len + 16'd8;
    // Pseudo-header plus UDP header; the UDP length appears twice (pseudo-header and header)
    seed = {16'h0, our_ip[31:16]} + {16'h0, our_ip[15:0]}
         + {16'h0, l4_dst_ip[31:16]} + {16'h0, l4_dst_ip[15:0]}
         + 32'h0000_0011 + {15'h0, l4_len8, 1'b0}
         + {16'h0, l4_src_port} + {16'h0, l4_dst_port};
    // End-around carry keeps the 32-bit accumulator a valid ones'-complement partial sum
    acc_sum  = {1'b0, acc} + {17'h0, data_masked[31:16]} + {17'h0, data_masked[15:0]};
    acc_next = acc_sum[31:0] + {31'h0, acc_sum[32]};
    // Two folds are enough: the second cannot carry out again
    fold1    = {1'b0, acc[31:16]} + {1'b0, acc[15:0]};
    fold2    = fold1[15:0] + {15'h0, fold1[16]};
    // A computed zero is transmitted as all-ones; zero means "no checksum" on the wire
    csum_raw = (fold2 == 16'hFFFF) ? 16'hFFFF : ~fold2;
  end
`else
  logic [15:0] csum_q;
  logic        unused_our_ip;
  assign csum_q        = 16'h0;
  assign unused_our_ip = ^our_ip;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= {bv_eff, data_masked};
    end
    rd_dat <= mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      tx_error   <= 1'b0;
      o_start    <= 1'b0;
      o_dvld     <= 1'b0;
      o_commit   <= 1'b0;
      o_dst_ip   <= 32'h0;
      o_data     <= 32'h0;
      o_protocol <= 8'h0;
      o_len      <= 16'h0;
      o_bv       <= 3'h0;
      dst_ip_q   <= 32'h0;
      src_port_q <= 16'h0;
      dst_port_q <= 16'h0;
      len_q      <= 16'h0;
      rx_bytes   <= 16'h0;
      out_cnt    <= 16'h0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
`ifdef UDP_TX_CHECKSUM_EN
      acc        <= 32'h0;
      csum_q     <= 16'h0;
`endif
    end else begin
      // Strobes and their qualifying fields are valid for exactly one cycle
      tx_error   <= 1'b0;
      o_start    <= 1'b0;
      o_dvld     <= 1'b0;
      o_commit   <= 1'b0;
      o_dst_ip   <= 32'h0;
      o_data     <= 32'h0;
      o_protocol <= 8'h0;
      o_len      <= 16'h0;
      o_bv       <= 3'h0;

      case (state)
        IDLE: begin
          if (l4_start) begin
            if (l4_len > MAX_LEN) begin
              tx_error <= 1'b1;
            end else begin
              dst_ip_q   <= l4_dst_ip;
              src_port_q <= l4_src_port;
              dst_port_q <= l4_dst_port;
              len_q      <= l4_len;
              rx_bytes   <= 16'h0;
              out_cnt    <= 16'h0;
              wr_ptr     <= '0;
              rd_ptr     <= '0;
              busy       <= 1'b1;
`ifdef UDP_TX_CHECKSUM_EN
              acc        <= seed;
`endif
              state      <= BUFFER;
            end
          end
        end

        BUFFER: begin
          if (l4_drop) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (l4_dvld && buf_full) begin
            tx_error <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            if (l4_dvld) begin
              wr_ptr   <= wr_ptr + PW'(1);
              rx_bytes <= rx_total;
`ifdef UDP_TX_CHECKSUM_EN
              acc      <= acc_next;
`endif
            end
            // rx_total already includes a word arriving alongside commit
            if (l4_commit) begin
              if (rx_total != len_q) begin
                tx_error <= 1'b1;
                busy     <= 1'b0;
                state    <= IDLE;
              end else begin
                state <= FOLD;
              end
            end
          end
        end

        FOLD: begin
`ifdef UDP_TX_CHECKSUM_EN
          csum_q <= csum_raw;
`endif
          o_start    <= 1'b1;
          o_dst_ip   <= dst_ip_q;
          o_protocol <= IP_PROTO_UDP;
          o_len      <= len8;
          state      <= L3_START;
        end

        L3_START: begin
          o_dvld <= 1'b1;
          o_bv   <= 3'd4;
          o_data <= {src_port_q, dst_port_q};
          state  <= HDR0;
        end

        // Word 0 read is launched here so it is in rd_dat when HDR1 is on the bus
        HDR0: begin
          o_dvld <= 1'b1;
          o_bv   <= 3'd4;
          o_data <= {len8, csum_q};
          rd_ptr <= rd_ptr + PW'(1);
          state  <= HDR1;
        end

        HDR1: begin
          if (n_words == 16'h0) begin
            o_commit <= 1'b1;
            state    <= COMMIT;
          end else begin
            o_dvld  <= 1'b1;
            o_bv    <= rd_dat[34:32];
            o_data  <= rd_dat[31:0];
            out_cnt <= 16'd1;
            rd_ptr  <= rd_ptr + PW'(1);
            state   <= BODY;
          end
        end

        BODY: begin
          if (out_cnt == n_words) begin
            o_commit <= 1'b1;
            state    <= COMMIT;
          end else begin
            o_dvld  <= 1'b1;
            o_bv    <= rd_dat[34:32];
            o_data  <= rd_dat[31:0];
            out_cnt <= out_cnt + 16'd1;
            rd_ptr  <= rd_ptr + PW'(1);
          end
        end

        COMMIT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_checksum_engine.sv
// tb_udp_tx_checksum_engine: directed vectors with a scoreboard queue of expected L3 events.
// Stimulus pushes expected events; a negedge monitor pops and compares each L3 strobe / tx_error.
module tb_udp_tx_checksum_engine;

`ifdef UDP_TX_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  localparam logic [31:0] OUR_IP = 32'h0A00_0001;
  localparam logic [31:0] DST    = 32'h0A00_0002;
  localparam logic [15:0] SPORT  = 16'd1234;
  localparam logic [15:0] DPORT  = 16'd5678;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [31:0]  our_ip;
  logic         l4_start, l4_dvld, l4_commit, l4_drop;
  logic [31:0]  l4_dst_ip, l4_data;
  logic [15:0]  l4_src_port, l4_dst_port, l4_len;
  logic [2:0]   l4_bv;
  logic [118:0] tx_l4_bus;
  logic [94:0]  tx_l3_bus;
  logic         busy, tx_error;

  assign tx_l4_bus = {l4_start, l4_dst_ip, l4_src_port, l4_dst_port, l4_len,
                      l4_data, l4_bv, l4_dvld, l4_commit, l4_drop};

  udp_tx_checksum_engine dut (
    .clk       (clk),
    .rst       (rst),
    .our_ip    (our_ip),
    .tx_l4_bus (tx_l4_bus),
    .tx_l3_bus (tx_l3_bus),
    .busy      (busy),
    .tx_error  (tx_error)
  );

  logic        l3_start, l3_dvld, l3_commit, l3_drop;
  logic [31:0] l3_dst_ip, l3_data;
  logic [7:0]  l3_proto;
  logic [15:0] l3_len;
  logic [2:0]  l3_bv;
  assign {l3_start, l3_dst_ip, l3_proto, l3_len, l3_data, l3_bv, l3_dvld, l3_commit, l3_drop} = tx_l3_bus;

  // kind: 0 start, 1 data word, 2 commit, 3 tx_error, 4 drop (never expected)
  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [23:0] b;
    int          delta;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  commit_cyc = 0;
  int  last_cyc = 0;
  bit  mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] cs(input logic [15:0] x);
    return CSUM_ON ? x : 16'h0000;
  endfunction

  task automatic push(input int kind, input logic [31:0] a, input logic [23:0] b, input int delta);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.delta = delta;
    exp_q.push_back(e);
  endtask

  // start (2 cycles after L4 commit), HDR0, HDR1 -- each following the previous by one cycle
  task automatic expect_hdr(input logic [15:0] len, input logic [15:0] csum);
    push(0, DST, {8'd17, len + 16'd8}, 2);
    push(1, {SPORT, DPORT}, 24'd4, 1);
    push(1, {len + 16'd8, cs(csum)}, 24'd4, 1);
  endtask

  task automatic mon_event(input int kind, input logic [31:0] a, input logic [23:0] b);
    ev_t e;
    int  d;
    d = cyc - ((kind == 0) ? commit_cyc : last_cyc);
    if (kind <= 2) last_cyc = cyc;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d a %h b %h at cycle %0d, expected none", kind, a, b, cyc);
    end else begin
      e = exp_q.pop_front();
      if (kind != e.kind || a !== e.a || b !== e.b || (e.delta >= 0 && d != e.delta)) begin
        errors++;
        $display("FAIL l3_event: got kind %0d a %h b %h gap %0d, expected kind %0d a %h b %h gap %0d",
                 kind, a, b, d, e.kind, e.a, e.b, e.delta);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (l3_drop)   mon_event(4, 32'h0, 24'h0);
      if (l3_start)  mon_event(0, l3_dst_ip, {l3_proto, l3_len});
      if (l3_dvld)   mon_event(1, l3_data, {21'h0, l3_bv});
      if (l3_commit) mon_event(2, 32'h0, 24'h0);
      if (tx_error)  mon_event(3, 32'h0, 24'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic l4_begin(input logic [15:0] len);
    l4_start = 1'b1; l4_dst_ip = DST; l4_src_port = SPORT; l4_dst_port = DPORT; l4_len = len;
    tick();
    l4_start = 1'b0;
  endtask

  task automatic l4_word(input logic [31:0] d, input logic [2:0] bv, input bit last);
    l4_dvld = 1'b1; l4_data = d; l4_bv = bv; l4_commit = last;
    if (last) commit_cyc = cyc;
    tick();
    l4_dvld = 1'b0; l4_data = 32'h0; l4_bv = 3'h0; l4_commit = 1'b0;
  endtask

  task automatic l4_commit_only();
    l4_commit = 1'b1;
    commit_cyc = cyc;
    tick();
    l4_commit = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check(name, 128'(busy), 128'h0);
    tick();
  endtask

  task automatic send_t1(input string name);
    expect_hdr(16'd4, 16'h3336);
    push(1, 32'hDEADBEEF, 24'd4, 1);
    push(2, 32'h0, 24'h0, 1);
    l4_begin(16'd4);
    l4_word(32'hDEADBEEF, 3'd4, 1'b1);
    wait_idle(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; our_ip = OUR_IP;
    l4_start = 1'b0; l4_dvld = 1'b0; l4_commit = 1'b0; l4_drop = 1'b0;
    l4_dst_ip = 32'h0; l4_data = 32'h0; l4_src_port = 16'h0; l4_dst_port = 16'h0;
    l4_len = 16'h0; l4_bv = 3'h0;
    repeat (3) tick();
    check("reset_l3_bus", 128'(tx_l3_bus), 128'h0);
    check("reset_busy", 128'(busy), 128'h0);
    check("reset_tx_error", 128'(tx_error), 128'h0);
    rst = 1'b0;
    tick();
    mon_en = 1'b1;

    // 1: 4-byte datagram, start/data+commit back to back
    expect_hdr(16'd4, 16'h3336);
    push(1, 32'hDEADBEEF, 24'd4, 1);
    push(2, 32'h0, 24'h0, 1);
    l4_begin(16'd4);
    check("busy_after_start", 128'(busy), 128'h1);
    l4_word(32'hDEADBEEF, 3'd4, 1'b1);
    wait_idle("t1_idle");

    // 2: 5-byte datagram, partial last word
    expect_hdr(16'd5, 16'hC7CB);
    push(1, 32'h01020304, 24'd4, 1);
    push(1, 32'h05000000, 24'd1, 1);
    push(2, 32'h0, 24'h0, 1);
    l4_begin(16'd5);
    l4_word(32'h01020304, 3'd4, 1'b0);
    l4_word(32'h05000000, 3'd1, 1'b1);
    wait_idle("t2_idle");

    // 3: payload crafted so the sum folds to 0xFFFF -> checksum 0 sent as 0xFFFF
    expect_hdr(16'd4, 16'hFFFF);
    push(1, 32'hD0D30000, 24'd4, 1);
    push(2, 32'h0, 24'h0, 1);
    l4_begin(16'd4);
    l4_word(32'hD0D30000, 3'd4, 1'b1);
    wait_idle("t3_idle");

    // 4a: short datagram -> tx_error, no L3 activity
    push(3, 32'h0, 24'h0, -1);
    l4_begin(16'd8);
    l4_word(32'hAAAA5555, 3'd4, 1'b1);
    check("t4_busy_after_short", 128'(busy), 128'h0);
    tick();

    // 4b: oversize start -> tx_error, not accepted
    push(3, 32'h0, 24'h0, -1);
    l4_begin(16'd1473);
    check("t4_oversize_busy", 128'(busy), 128'h0);
    tick();

    // 5: drop in BUFFER, then an intact datagram
    l4_begin(16'd12);
    l4_word(32'h11111111, 3'd4, 1'b0);
    l4_word(32'h22222222, 3'd4, 1'b0);
    l4_drop = 1'b1;
    tick();
    l4_drop = 1'b0;
    check("t5_busy_after_drop", 128'(busy), 128'h0);
    tick();
    send_t1("t5_resend_idle");

    // 6: reset while the first body word is on the bus
    expect_hdr(16'd8, 16'hBF76);
    push(1, 32'h11223344, 24'd4, 1);
    l4_begin(16'd8);
    l4_word(32'h11223344, 3'd4, 1'b0);
    l4_word(32'h55667788, 3'd4, 1'b1);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("t6_rst_l3_bus", 128'(tx_l3_bus), 128'h0);
    check("t6_rst_busy", 128'(busy), 128'h0);
    check("t6_rst_tx_error", 128'(tx_error), 128'h0);
    rst = 1'b0;
    tick();

    // 6b: zero-length datagram skips BODY
    expect_hdr(16'd0, 16'hD0DB);
    push(2, 32'h0, 24'h0, 1);
    l4_begin(16'd0);
    l4_commit_only();
    wait_idle("t6_zero_idle");

    repeat (5) tick();
    check("scoreboard_drained", 128'(exp_q.size()), 128'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
